// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: start detection, per-bit edge/bit counting,
// start/parity/stop checking and one-cycle status pulses.
module uart_rx_ctrl #(
  parameter int PRESCALE_W = 6,
  parameter int DATA_BITS  = 8
) (
  input  logic                  clk_based_on_prescale,
  input  logic                  rst_n,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_data,
  input  logic                  sampled_data_valid,
  input  logic [DATA_BITS-1:0]  parallel_data,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  data_samp_en,
  output logic                  Deserializer_enable,
  output logic [DATA_BITS-1:0]  data_out,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_glitch,
  output logic                  frm_err
);

  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  sample_q, sample_d;
  logic                  seen_q, seen_d;
  logic                  par_flag_q, par_flag_d;
  logic [DATA_BITS-1:0]  data_d;
  logic                  dv_d, par_err_d, stp_err_d, glitch_d, frm_d;
  logic                  boundary, cur_sample, cur_seen;

  assign boundary   = (state_q != S_IDLE) && (edge_cnt == presc_q - PRESCALE_W'(1));
  // A strobe landing on the boundary cycle decides that bit directly.
  assign cur_sample = sampled_data_valid ? sampled_data : sample_q;
  assign cur_seen   = seen_q | sampled_data_valid;

  assign data_samp_en        = (state_q != S_IDLE);
  assign Deserializer_enable = (state_q == S_DATA);

  always_comb begin
    state_d    = state_q;
    edge_d     = edge_cnt;
    presc_d    = presc_q;
    bit_d      = bit_q;
    sample_d   = sample_q;
    seen_d     = seen_q;
    par_flag_d = par_flag_q;
    data_d     = data_out;
    dv_d       = 1'b0;
    par_err_d  = 1'b0;
    stp_err_d  = 1'b0;
    glitch_d   = 1'b0;
    frm_d      = 1'b0;

    if (state_q == S_IDLE) begin
      edge_d     = '0;
      seen_d     = 1'b0;
      par_flag_d = 1'b0;
      if (!RX_IN) begin
        state_d = S_START;
        presc_d = Prescale;
      end
    end else begin
      edge_d = boundary ? '0 : edge_cnt + PRESCALE_W'(1);
      if (sampled_data_valid) begin
        sample_d = sampled_data;
        seen_d   = 1'b1;
      end
      if (boundary) begin
        seen_d = 1'b0;
        if (!cur_seen) begin
          frm_d      = 1'b1;
          state_d    = S_IDLE;
          bit_d      = '0;
          par_flag_d = 1'b0;
        end else begin
          case (state_q)
            S_START: begin
              if (cur_sample) begin
                glitch_d = 1'b1;
                state_d  = S_IDLE;
              end else begin
                state_d = S_DATA;
                bit_d   = '0;
              end
            end
            S_DATA: begin
              if (bit_q == LAST_BIT) begin
                bit_d   = '0;
                state_d = PAR_EN ? S_PARITY : S_STOP;
              end else begin
                bit_d = bit_q + BIT_W'(1);
              end
            end
            S_PARITY: begin
              if (cur_sample != ((^parallel_data) ^ PAR_TYP)) par_flag_d = 1'b1;
              state_d = S_STOP;
            end
            S_STOP: begin
              stp_err_d  = ~cur_sample;
              par_err_d  = par_flag_q;
              if (cur_sample && !par_flag_q) begin
                dv_d   = 1'b1;
                data_d = parallel_data;
              end
              par_flag_d = 1'b0;
              // A low line on the stop boundary is the next frame's start edge.
              if (!RX_IN) begin
                state_d = S_START;
                presc_d = Prescale;
              end else begin
                state_d = S_IDLE;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_based_on_prescale or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      edge_cnt    <= '0;
      presc_q     <= '0;
      bit_q       <= '0;
      sample_q    <= 1'b0;
      seen_q      <= 1'b0;
      par_flag_q  <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      strt_glitch <= 1'b0;
      frm_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      edge_cnt    <= edge_d;
      presc_q     <= presc_d;
      bit_q       <= bit_d;
      sample_q    <= sample_d;
      seen_q      <= seen_d;
      par_flag_q  <= par_flag_d;
      data_out    <= data_d;
      data_valid  <= dv_d;
      par_err     <= par_err_d;
      stp_err     <= stp_err_d;
      strt_glitch <= glitch_d;
      frm_err     <= frm_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed frame table, randomized frames against a
// frame-level outcome model, and a mid-frame reset sequence.
module tb_uart_rx_ctrl;

  localparam int PW = 6;
  localparam int DB = 8;
  localparam logic [4:0] M_DV  = 5'b00001;
  localparam logic [4:0] M_PAR = 5'b00010;
  localparam logic [4:0] M_STP = 5'b00100;
  localparam logic [4:0] M_GLT = 5'b01000;
  localparam logic [4:0] M_FRM = 5'b10000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] Prescale = 6'd8;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          sampled_data = 1'b0;
  logic          sampled_data_valid = 1'b0;
  logic [DB-1:0] parallel_data = '0;
  logic [PW-1:0] edge_cnt;
  logic          data_samp_en, Deserializer_enable;
  logic [DB-1:0] data_out;
  logic          data_valid, par_err, stp_err, strt_glitch, frm_err;

  uart_rx_ctrl #(.PRESCALE_W(PW), .DATA_BITS(DB)) dut (
    .clk_based_on_prescale(clk),
    .rst_n(rst_n),
    .RX_IN(RX_IN),
    .Prescale(Prescale),
    .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP),
    .sampled_data(sampled_data),
    .sampled_data_valid(sampled_data_valid),
    .parallel_data(parallel_data),
    .edge_cnt(edge_cnt),
    .data_samp_en(data_samp_en),
    .Deserializer_enable(Deserializer_enable),
    .data_out(data_out),
    .data_valid(data_valid),
    .par_err(par_err),
    .stp_err(stp_err),
    .strt_glitch(strt_glitch),
    .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  // Deserializer stand-in: LSB-first shift on each qualified sample.
  always @(posedge clk)
    if (Deserializer_enable && sampled_data_valid)
      parallel_data <= {sampled_data, parallel_data[DB-1:1]};

  typedef struct {
    int unsigned presc;
    bit          par_en;
    bit          par_typ;
    logic [7:0]  data;
    bit          par_bit;
    bit          stop_bit;
    int          drop_pos;
    bit          start_val;
    bit          glitch;
    int unsigned soff;
    int unsigned gap;
  } frame_t;

  typedef struct {
    logic [4:0]  mask;
    int unsigned step;
    logic [7:0]  data;
  } ev_t;

  typedef struct {
    frame_t      f;
    logic [4:0]  mask;
    int unsigned off;
    logic [7:0]  dout;
    int unsigned de;
  } vec_t;

  ev_t         act_q[$], exp_q[$];
  int unsigned act_de[$], exp_de[$], act_en[$], exp_en[$];
  int unsigned step_no = 0, de_acc = 0, en_acc = 0;
  bit          carry_v = 1'b0;
  logic        carry_d = 1'b0;
  int unsigned n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rx, input logic sv, input logic sd);
    logic [4:0] m;
    if (carry_v) begin
      sv = 1'b1;
      sd = carry_d;
      carry_v = 1'b0;
    end
    RX_IN = rx;
    sampled_data_valid = sv;
    sampled_data = sd;
    @(posedge clk);
    @(negedge clk);
    m = {frm_err, strt_glitch, stp_err, par_err, data_valid};
    if (m != 5'b0) act_q.push_back('{m, step_no, data_out});
    if (Deserializer_enable) de_acc++;
    if (data_samp_en) en_acc++;
    step_no++;
  endtask

  function automatic logic bit_val(input frame_t f, input int unsigned b);
    if (b == 0) return 1'b0;
    if (b <= 8) return f.data[b-1];
    if (f.par_en && b == 9) return f.par_bit;
    return f.stop_bit;
  endfunction

  // Drives bit positions 0..last_pos, then the idle gap.
  task automatic drive_frame(input frame_t f, input int unsigned last_pos);
    logic val, sval, rx;
    bit   stb;
    de_acc  = 0;
    en_acc  = 0;
    PAR_EN  = f.par_en;
    PAR_TYP = f.par_typ;
    for (int unsigned b = 0; b <= last_pos; b++) begin
      val  = bit_val(f, b);
      sval = (b == 0) ? logic'(f.start_val) : val;
      for (int unsigned c = 0; c < f.presc; c++) begin
        if (b == 0 && c == 0) Prescale = PW'(f.presc);
        else if (b == 0 && c == 1) Prescale = PW'($urandom_range(4, 32));
        rx  = (b == 0 && f.glitch) ? logic'(c >= 3) : val;
        stb = (int'(b) != f.drop_pos) && (c == f.soff);
        step(rx, stb, stb ? sval : logic'($urandom_range(0, 1)));
      end
      if (f.soff == f.presc && int'(b) != f.drop_pos) begin
        carry_v = 1'b1;
        carry_d = sval;
      end
    end
    for (int unsigned g = 0; g < f.gap; g++) step(1'b1, 1'b0, 1'b0);
    act_de.push_back(de_acc);
    act_en.push_back(en_acc);
  endtask

  // Frame-level outcome: which bit position ends the frame and how.
  function automatic void predict(input frame_t f, inout logic [7:0] good,
                                  output logic [4:0] mask, output int unsigned off,
                                  output logic [7:0] dout, output int unsigned de,
                                  output int unsigned last_pos);
    int unsigned nb = 10 + (f.par_en ? 1 : 0);
    last_pos = nb - 1;
    mask = 5'b0;
    if (f.drop_pos == 0) begin
      last_pos = 0; mask = M_FRM;
    end else if (f.start_val) begin
      last_pos = 0; mask = M_GLT;
    end else if (f.drop_pos > 0 && f.drop_pos < int'(nb)) begin
      last_pos = f.drop_pos; mask = M_FRM;
    end else begin
      if (!f.stop_bit) mask |= M_STP;
      if (f.par_en && (f.par_bit != ((^f.data) ^ f.par_typ))) mask |= M_PAR;
      if (mask == 5'b0) begin
        mask = M_DV;
        good = f.data;
      end
    end
    off  = (last_pos + 1) * f.presc;
    dout = good;
    de   = (last_pos > 8 ? 8 : last_pos) * f.presc;
  endfunction

  task automatic compare_batch(input string tag);
    check({tag, "_ev_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      check($sformatf("%s_mask%0d", tag, i), act_q[i].mask, exp_q[i].mask);
      check($sformatf("%s_step%0d", tag, i), act_q[i].step, exp_q[i].step);
      check($sformatf("%s_dout%0d", tag, i), act_q[i].data, exp_q[i].data);
    end
    for (int i = 0; i < exp_de.size() && i < act_de.size(); i++) begin
      check($sformatf("%s_deser_cycles%0d", tag, i), act_de[i], exp_de[i]);
      check($sformatf("%s_samp_en_cycles%0d", tag, i), act_en[i], exp_en[i]);
    end
    act_q.delete(); exp_q.delete();
    act_de.delete(); exp_de.delete();
    act_en.delete(); exp_en.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pulses"}, {frm_err, strt_glitch, stp_err, par_err, data_valid}, 5'b0);
    check({tag, "_enables"}, {data_samp_en, Deserializer_enable}, 2'b0);
    check({tag, "_edge_cnt"}, edge_cnt, 0);
    check({tag, "_data_out"}, data_out, 0);
  endtask

  initial begin
    vec_t        tbl[12];
    frame_t      f;
    logic [7:0]  good;
    logic [4:0]  m;
    int unsigned off, de, lp, base, nb;

    //            presc par typ data    pbit stop drop start glt soff gap   mask         off  dout   de
    tbl[0]  = '{'{8,  1'b0, 1'b0, 8'hCD, 1'b0, 1'b1, -1, 1'b0, 1'b0, 4,  5}, M_DV,        80,  8'hCD, 64};
    tbl[1]  = '{'{16, 1'b1, 1'b0, 8'hCD, 1'b1, 1'b1, -1, 1'b0, 1'b0, 8,  3}, M_DV,        176, 8'hCD, 128};
    tbl[2]  = '{'{16, 1'b1, 1'b0, 8'hCD, 1'b0, 1'b1, -1, 1'b0, 1'b0, 8,  3}, M_PAR,       176, 8'hCD, 128};
    tbl[3]  = '{'{8,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, -1, 1'b1, 1'b1, 4,  4}, M_GLT,       8,   8'hCD, 0};
    tbl[4]  = '{'{8,  1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, -1, 1'b0, 1'b0, 4,  3}, M_STP,       80,  8'hCD, 64};
    tbl[5]  = '{'{8,  1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 4,  1'b0, 1'b0, 4,  3}, M_FRM,       40,  8'hCD, 32};
    tbl[6]  = '{'{8,  1'b0, 1'b0, 8'h55, 1'b0, 1'b1, -1, 1'b0, 1'b0, 4,  0}, M_DV,        80,  8'h55, 64};
    tbl[7]  = '{'{8,  1'b0, 1'b0, 8'hA3, 1'b0, 1'b1, -1, 1'b0, 1'b0, 4,  4}, M_DV,        80,  8'hA3, 64};
    tbl[8]  = '{'{4,  1'b1, 1'b1, 8'h0F, 1'b1, 1'b1, -1, 1'b0, 1'b0, 4,  3}, M_DV,        44,  8'h0F, 32};
    tbl[9]  = '{'{32, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, -1, 1'b0, 1'b0, 31, 3}, M_DV,        320, 8'h81, 256};
    tbl[10] = '{'{8,  1'b1, 1'b1, 8'h01, 1'b1, 1'b0, -1, 1'b0, 1'b0, 3,  3}, M_PAR|M_STP, 88,  8'h81, 64};
    tbl[11] = '{'{8,  1'b0, 1'b0, 8'h77, 1'b0, 1'b1, 9,  1'b0, 1'b0, 5,  3}, M_FRM,       80,  8'h81, 64};

    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    repeat (3) step(1'b1, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      base = step_no;
      drive_frame(tbl[i].f, tbl[i].off / tbl[i].f.presc - 1);
      exp_q.push_back('{tbl[i].mask, base + tbl[i].off, tbl[i].dout});
      exp_de.push_back(tbl[i].de);
      exp_en.push_back(tbl[i].off);
    end
    compare_batch("table");

    good = tbl[11].dout;
    for (int n = 0; n < 40; n++) begin
      f.presc     = $urandom_range(4, 32);
      f.par_en    = 1'($urandom_range(0, 1));
      f.par_typ   = 1'($urandom_range(0, 1));
      f.data      = 8'($urandom);
      nb          = 10 + (f.par_en ? 1 : 0);
      f.par_bit   = ($urandom_range(0, 3) != 0) ? bit'((^f.data) ^ f.par_typ) : bit'(~((^f.data) ^ f.par_typ));
      f.stop_bit  = ($urandom_range(0, 6) != 0);
      f.drop_pos  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      f.start_val = ($urandom_range(0, 11) == 0);
      f.glitch    = 1'b0;
      f.soff      = $urandom_range(1, f.presc);
      base = step_no;
      predict(f, good, m, off, good, de, lp);
      f.gap = ($urandom_range(0, 2) == 0 && lp == nb - 1 && m != M_FRM && n != 39) ? 0 : $urandom_range(1, 5);
      drive_frame(f, lp);
      exp_q.push_back('{m, base + off, good});
      exp_de.push_back(de);
      exp_en.push_back(off);
    end
    compare_batch("rand");
    check("rand_data_out_hold", data_out, good);

    // Abort a frame in DATA with reset, then receive one clean frame.
    Prescale = 6'd8;
    PAR_EN = 1'b0;
    for (int c = 0; c < 8; c++) step(1'b0, c == 4, 1'b0);
    for (int b = 0; b < 3; b++)
      for (int c = 0; c < 8; c++) step(logic'(b % 2), c == 4, logic'(b % 2));
    check("pre_reset_in_data", Deserializer_enable, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_state("midframe_reset");
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    act_q.delete();
    good = 8'h00;
    f = '{8, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, -1, 1'b0, 1'b0, 4, 3};
    base = step_no;
    predict(f, good, m, off, good, de, lp);
    drive_frame(f, lp);
    exp_q.push_back('{m, base + off, good});
    exp_de.push_back(de);
    exp_en.push_back(off);
    check("post_reset_data_out", data_out, 8'h3C);
    compare_batch("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Frame-sequencing controller for the UART receive path. It detects the start edge on RX_IN, runs the per-bit edge counter and bit counter, and enables the Deserializer during data bits. It also checks the start, parity and stop bits, and issues a one-cycle data_valid with the captured byte. It sits between the RX pin, the data sampler (sampled_data / sampled_data_valid) and the Deserializer (Deserializer_enable / parallel_data).

Parameters:
PRESCALE_W, 6, width of Prescale and edge_cnt
DATA_BITS, 8, data bits per frame, LSB first

Ports:
clk_based_on_prescale  input  1  oversampling clock; all logic on its rising edge
rst_n  input  1  asynchronous active-low reset
RX_IN  input  1  serial line, idle high
Prescale  input  PRESCALE_W  oversampling ratio; legal 4..32
PAR_EN  input  1  1 = parity bit present
PAR_TYP  input  1  0 = even, 1 = odd
sampled_data  input  1  sampler's bit decision
sampled_data_valid  input  1  one-cycle strobe qualifying sampled_data
parallel_data  input  DATA_BITS  Deserializer output
edge_cnt  output  PRESCALE_W  edge position within current bit, to sampler
data_samp_en  output  1  sampler enable; high in every state except IDLE
Deserializer_enable  output  1  high only in DATA
data_out  output  DATA_BITS  last good byte
data_valid  output  1  one-cycle pulse, data_out updated same cycle
par_err  output  1  one-cycle pulse
stp_err  output  1  one-cycle pulse
strt_glitch  output  1  one-cycle pulse
frm_err  output  1  one-cycle pulse, missing sample

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs, edge_cnt, bit_cnt, prescale latch, sample latch and par_flag are 0. Reset mid-frame aborts immediately; no pulses are emitted.
- States: IDLE, START, DATA, PARITY, STOP.
- Prescale is latched on leaving IDLE and on STOP->START. Changes mid-frame are ignored.
- Edge counting (all states except IDLE): edge_cnt increments each cycle. Bit boundary = cycle where edge_cnt == latched Prescale-1; edge_cnt wraps to 0 there.
- Sample latch: on sampled_data_valid=1, sample<=sampled_data and seen<=1. seen clears at each boundary. If strobe and boundary coincide, the strobe value is used for that boundary.
- Boundary with seen=0 (and no coincident strobe): frm_err pulse next cycle, go IDLE.
- IDLE: RX_IN=0 -> START, edge_cnt=0.
- START, boundary: sample=0 -> DATA, bit_cnt=0. sample=1 -> strt_glitch pulse, IDLE.
- DATA: Deserializer_enable=1. At each boundary bit_cnt++. At the boundary with bit_cnt==DATA_BITS-1: go PARITY if PAR_EN, else STOP; bit_cnt=0.
- PARITY, boundary: expected = (^parallel_data) ^ PAR_TYP. On mismatch set par_flag. Go STOP.
- STOP, boundary:
  - sample=0 -> stp_err pulse.
  - par_flag=1 -> par_err pulse.
  - Both clean -> data_valid pulse, data_out<=parallel_data.
  - par_flag clears.
  - Next state: if RX_IN=0 this cycle -> START (edge_cnt=0, back-to-back frames, no idle cycle); else IDLE.
- All pulses are registered: asserted the cycle after the deciding boundary, for exactly one cycle. data_out holds until the next good frame.
- Latency: data_valid = 1 cycle after the last stop-bit edge.
- Frame length: (2 + DATA_BITS + PAR_EN) * Prescale cycles from the START entry edge to the STOP boundary.

Test Plan:
1. Prescale=8, PAR_EN=0: frame 0 / bits 1,0,1,1,0,0,1,1 / 1 -> data_valid one cycle, data_out=0xCD, Deserializer_enable high for exactly 64 cycles, no error pulses.
2. Prescale=16, PAR_EN=1, PAR_TYP=0: byte 0xCD with parity bit 1 -> data_valid, data_out=0xCD. Repeat with parity bit 0 -> par_err pulse, no data_valid, data_out still 0xCD.
3. Prescale=8: RX_IN low for 3 cycles, then high with sampler returning 1 for the start bit -> strt_glitch at cycle 9, state IDLE, Deserializer_enable never asserted.
4. Prescale=8: stop bit sampled 0 -> stp_err pulse, no data_valid. Separately, suppress sampled_data_valid during data bit 3 -> frm_err, return to IDLE.
5. Two frames 0x55 then 0xA3, back-to-back with no idle gap, Prescale=8 -> two data_valid pulses exactly 80 cycles apart, correct bytes.
6. rst_n low during DATA of a frame, released 2 cycles later, then one clean frame 0x3C -> no pulse from the aborted frame, data_valid with 0x3C.
